fetch_stall_controller: RTL and testbench
=========================================

Name: fetch_stall_controller

Overview:
- Fetch-side partner of the hazard/stall logic.
- Drives the PC and instruction-memory address, and decodes rs1/rs2/rd/branch from the fetched word for the hazard unit.
- Honours the hazard unit's stall request by holding the PC and injecting NOP bubbles, and reports is_stall back so the replayed word is not re-evaluated.
- Sits between instruction memory and the decode stage; also accepts branch redirects from execute.

Parameters:
XLEN, 32, address/instruction width
RESET_PC, 32'h0000_0000, PC loaded on reset
NOP_WORD, 32'h0000_0013, bubble instruction (addi x0,x0,0)

Ports:
clk  in  1  Clock, rising edge active for this block
rst  in  1  synchronous, active-high reset
stall  in  1  stall request from hazard unit (changes on negedge)
branch_taken  in  1  redirect request from execute
branch_target  in  XLEN  redirect PC, word aligned
imem_data  in  XLEN  instruction word at imem_addr (combinational read)
imem_addr  out  XLEN  current PC
is_stall  out  1  registered: held word is a replay
rs1  out  5  RegId decoded from imem_data, 0 if unused by format
rs2  out  5  RegId, 0 if unused
rd  out  5  RegId, 0 if no writeback or if stall high
branch  out  1  Bool: imem_data is B-type, JAL or JALR
instr_out  out  XLEN  registered instruction to decode
pc_out  out  XLEN  registered PC of instr_out
instr_valid  out  1  instr_out is a real (non-bubble) instruction

Behaviour:
- Reset (rst high at posedge): pc=RESET_PC, instr_out=NOP_WORD, pc_out=RESET_PC, instr_valid=0, is_stall=0. Reset mid-operation discards any pending redirect or stall.
- Each posedge, priority order: rst > branch_taken > stall > advance.
  - branch_taken: pc<=branch_target; instr_out<=NOP_WORD; instr_valid<=0; is_stall<=0. The wrong-path word is dropped.
  - stall: pc held; instr_out<=NOP_WORD; instr_valid<=0; is_stall<=1.
  - advance: pc<=pc+4 (mod 2^XLEN, wraps silently); instr_out<=imem_data; pc_out<=pc; instr_valid<=1; is_stall<=0.
- State: RUN (is_stall=0) and HOLD (is_stall=1).
  - RUN->HOLD on stall without branch_taken.
  - HOLD->RUN when stall is low or on branch_taken.
- Latency: one cycle from imem_data to instr_out. imem_addr = pc, combinational from the register.
- Decode (combinational from imem_data):
  - rs1 = 0 for U/J types (LUI, AUIPC, JAL).
  - rs2 = 0 except R, S, B types.
  - rd = 0 for S/B types, x0, or when stall is high (the un-issued word must not enter the hazard history).
  - branch = 1 for opcodes 1100011, 1101111, 1100111.
  - Unknown opcode: all RegIds 0, branch=0.
- Consecutive stalls: PC stays frozen for any number of cycles and the same word is replayed. The hazard unit's two post-branch stalls yield exactly two bubbles.
- branch_taken during HOLD: redirect wins, stall ignored for that cycle. is_stall must be 0 the next cycle.
- branch_target misaligned (bits[1:0]!=0): low bits forced to 0.

Optional Feature:
Macro FETCH_PERF_COUNTERS_EN.
- Defined: adds outputs stall_cycles (32b), bubble_count (32b) and redirect_count (32b), all zeroed on rst.
  - stall_cycles increments each posedge with stall high and branch_taken low.
  - bubble_count increments each posedge with instr_valid<=0 from branch or stall.
  - redirect_count increments on branch_taken.
  - All three saturate at 32'hFFFF_FFFF.
- Undefined: ports and logic absent; behaviour otherwise identical.

Decomposition:
- Shared package: Clock, Bool, BoolReg, RegId, RegIdReg typedefs; opcode constants (OP_BRANCH, OP_JAL, OP_JALR, OP_STORE, OP_LUI, OP_AUIPC, OP_OP, OP_OPIMM, OP_LOAD); NOP_WORD constant.
- One sub-module, instr_field_decode: combinational extraction of rs1/rs2/rd/branch with format masking. The stall-gating of rd stays in the parent.

Test Plan:
- Reset, then rst low; imem returns 0x00500093 (addi x1,x0,5) -> imem_addr 0,4,8; instr_out=0x00500093, pc_out=0, instr_valid=1 one cycle after; rd=1, rs1=0, rs2=0.
- stall high for 3 posedges at pc=8 -> imem_addr stays 8; instr_out=NOP_WORD, instr_valid=0, is_stall=1 for 3 cycles; rd=0 throughout; advance to 12 after release.
- Word 0x00208463 (beq x1,x2) at pc=16 -> branch=1, rs1=1, rs2=2, rd=0. Two following stall cycles produce exactly two bubbles.
- branch_taken with branch_target=0x100 while stall high -> next imem_addr=0x100, instr_valid=0, is_stall=0.
- pc=0xFFFF_FFFC, advance -> imem_addr wraps to 0.
- With FETCH_PERF_COUNTERS_EN: 3 stalls + 1 redirect -> stall_cycles=3, bubble_count=4, redirect_count=1; rst mid-run clears all to 0.

Source files
------------

// File: rtl/fetch_stall_controller_pkg.sv
// fetch_stall_controller_pkg: shared types, opcodes and FSM states for the fetch stage
package fetch_stall_controller_pkg;
  typedef logic clock_t;
  typedef logic bool_t;
  typedef logic bool_reg_t;
  typedef logic [4:0] reg_id_t;
  typedef logic [4:0] reg_id_reg_t;
  typedef enum logic {RUN, HOLD} fetch_state_t;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_LUI = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_OP = 7'b0110011;
  localparam logic [6:0] OP_OPIMM = 7'b0010011;
  localparam logic [6:0] OP_LOAD = 7'b0000011;
  localparam logic [31:0] NOP_WORD = 32'h0000_0013;
endpackage

// File: rtl/instr_field_decode.sv
// instr_field_decode: register-id and branch extraction with per-format masking
module instr_field_decode
  import fetch_stall_controller_pkg::*;
(
  input  logic [31:0] instr,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2,
  output logic [4:0]  rd,
  output logic        branch
);
  logic [6:0] op;
  bool_t use_rs1, use_rs2, use_rd;
  logic unused_bits;
  assign op = instr[6:0];
  assign use_rs1 = op inside {OP_JALR, OP_BRANCH, OP_STORE, OP_OP, OP_OPIMM, OP_LOAD};
  assign use_rs2 = op inside {OP_OP, OP_STORE, OP_BRANCH};
  assign use_rd = op inside {OP_JAL, OP_JALR, OP_LUI, OP_AUIPC, OP_OP, OP_OPIMM, OP_LOAD};
  assign branch = op inside {OP_BRANCH, OP_JAL, OP_JALR};
  assign rs1 = use_rs1 ? instr[19:15] : '0;
  assign rs2 = use_rs2 ? instr[24:20] : '0;
  assign rd = use_rd ? instr[11:7] : '0;
  assign unused_bits = ^{instr[31:25], instr[14:12]};
endmodule

// File: rtl/fetch_stall_controller.sv
// fetch_stall_controller: PC/fetch with stall bubbles and redirects; FETCH_PERF_COUNTERS_EN adds counters
module fetch_stall_controller
  import fetch_stall_controller_pkg::*;
#(
  parameter int XLEN = 32,
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
  parameter logic [XLEN-1:0] NOP_WORD = 32'h0000_0013
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            branch_taken,
  input  logic [XLEN-1:0] branch_target,
  input  logic [XLEN-1:0] imem_data,
  output logic [XLEN-1:0] imem_addr,
  output logic            is_stall,
  output logic [4:0]      rs1,
  output logic [4:0]      rs2,
  output logic [4:0]      rd,
  output logic            branch,
  output logic [XLEN-1:0] instr_out,
  output logic [XLEN-1:0] pc_out,
  output logic            instr_valid
`ifdef FETCH_PERF_COUNTERS_EN
  ,
  output logic [31:0]     stall_cycles,
  output logic [31:0]     bubble_count,
  output logic [31:0]     redirect_count
`endif
);
  fetch_state_t state;
  logic [XLEN-1:0] pc;
  logic [4:0] dec_rd;
  logic unused_target;
  instr_field_decode u_decode (
    .instr  (imem_data[31:0]),
    .rs1    (rs1),
    .rs2    (rs2),
    .rd     (dec_rd),
    .branch (branch)
  );
  // a stalled word is not issued, so it must not appear as a writer to the hazard unit
  assign rd = stall ? '0 : dec_rd;
  assign imem_addr = pc;
  assign is_stall = state == HOLD;
  assign unused_target = ^branch_target[1:0];
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RUN;
      pc <= RESET_PC;
      pc_out <= RESET_PC;
      instr_out <= NOP_WORD;
      instr_valid <= 1'b0;
    end else if (branch_taken) begin
      state <= RUN;
      pc <= {branch_target[XLEN-1:2], 2'b00};
      instr_out <= NOP_WORD;
      instr_valid <= 1'b0;
    end else if (stall) begin
      state <= HOLD;
      instr_out <= NOP_WORD;
      instr_valid <= 1'b0;
    end else begin
      state <= RUN;
      pc <= pc + XLEN'(4);
      pc_out <= pc;
      instr_out <= imem_data;
      instr_valid <= 1'b1;
    end
  end
`ifdef FETCH_PERF_COUNTERS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles <= '0;
      bubble_count <= '0;
      redirect_count <= '0;
    end else begin
      if (stall && !branch_taken && stall_cycles != '1) stall_cycles <= stall_cycles + 32'd1;
      if ((stall || branch_taken) && bubble_count != '1) bubble_count <= bubble_count + 32'd1;
      if (branch_taken && redirect_count != '1) redirect_count <= redirect_count + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_fetch_stall_controller.sv
// tb_fetch_stall_controller: directed checks of fetch, stall bubbles, redirects, wrap and decode
module tb_fetch_stall_controller;
  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] ADDI1 = 32'h0050_0093;
  localparam logic [31:0] ADDI2 = 32'h0070_0113;
  localparam logic [31:0] BEQ = 32'h0020_8463;
  logic clk = 1'b0;
  logic rst, stall, branch_taken;
  logic [31:0] branch_target, imem_data, imem_addr, instr_out, pc_out;
  logic is_stall, branch, instr_valid;
  logic [4:0] rs1, rs2, rd;
  logic use_ovr;
  logic [31:0] ovr;
`ifdef FETCH_PERF_COUNTERS_EN
  logic [31:0] stall_cycles, bubble_count, redirect_count;
`endif
  int tests = 0;
  int fails = 0;
  always #5 clk = ~clk;
  always_comb imem_data = use_ovr ? ovr : imem_addr == 32'h10 ? BEQ : imem_addr == 32'hFFFF_FFFC ? ADDI2 : ADDI1;
  fetch_stall_controller dut (
    .clk           (clk),
    .rst           (rst),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .imem_data     (imem_data),
    .imem_addr     (imem_addr),
    .is_stall      (is_stall),
    .rs1           (rs1),
    .rs2           (rs2),
    .rd            (rd),
    .branch        (branch),
    .instr_out     (instr_out),
    .pc_out        (pc_out),
    .instr_valid   (instr_valid)
`ifdef FETCH_PERF_COUNTERS_EN
    ,
    .stall_cycles   (stall_cycles),
    .bubble_count   (bubble_count),
    .redirect_count (redirect_count)
`endif
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic check_fetch(input string tag, input logic [31:0] addr, input logic [31:0] instr,
                             input logic [31:0] pc, input logic valid, input logic stl);
    check({tag, ".addr"}, imem_addr, addr);
    check({tag, ".instr"}, instr_out, instr);
    check({tag, ".pc_out"}, pc_out, pc);
    check({tag, ".valid"}, 32'(instr_valid), 32'(valid));
    check({tag, ".is_stall"}, 32'(is_stall), 32'(stl));
  endtask
  typedef struct {logic [31:0] w; logic [15:0] exp;} dec_vec_t;
  dec_vec_t dec_tab[9];
  initial begin
    // expected {branch, rs1, rs2, rd}
    dec_tab[0] = '{32'h0020_A023, {1'b0, 5'd1, 5'd2, 5'd0}};
    dec_tab[1] = '{32'h1234_52B7, {1'b0, 5'd0, 5'd0, 5'd5}};
    dec_tab[2] = '{32'h0080_00EF, {1'b1, 5'd0, 5'd0, 5'd1}};
    dec_tab[3] = '{32'h0000_8067, {1'b1, 5'd1, 5'd0, 5'd0}};
    dec_tab[4] = '{32'h0020_81B3, {1'b0, 5'd1, 5'd2, 5'd3}};
    dec_tab[5] = '{32'h0000_A203, {1'b0, 5'd1, 5'd0, 5'd4}};
    dec_tab[6] = '{32'h0000_0317, {1'b0, 5'd0, 5'd0, 5'd6}};
    dec_tab[7] = '{32'hFFFF_FFFF, {1'b0, 5'd0, 5'd0, 5'd0}};
    dec_tab[8] = '{BEQ, {1'b1, 5'd1, 5'd2, 5'd0}};
    rst = 1'b1; stall = 1'b0; branch_taken = 1'b0; branch_target = '0; use_ovr = 1'b0; ovr = '0;
    tick(); tick();
    check_fetch("reset", 32'h0, NOP, 32'h0, 1'b0, 1'b0);
    check("reset.dec", {11'd0, rs1, rs2, rd}, {11'd0, 5'd0, 5'd0, 5'd1});
    rst = 1'b0;
    tick();
    check_fetch("adv1", 32'h4, ADDI1, 32'h0, 1'b1, 1'b0);
    tick();
    check_fetch("adv2", 32'h8, ADDI1, 32'h4, 1'b1, 1'b0);
    stall = 1'b1;
    #1 check("stall.rd_gate", 32'(rd), 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check_fetch($sformatf("stall%0d", i), 32'h8, NOP, 32'h4, 1'b0, 1'b1);
      check($sformatf("stall%0d.rd", i), 32'(rd), 32'd0);
    end
    stall = 1'b0;
    tick();
    check_fetch("release", 32'hC, ADDI1, 32'h8, 1'b1, 1'b0);
    tick();
    check("beq.dec", {15'd0, branch, rs1, rs2, rd}, {15'd0, 1'b1, 5'd1, 5'd2, 5'd0});
    stall = 1'b1;
    tick();
    check_fetch("beq.bub0", 32'h10, NOP, 32'hC, 1'b0, 1'b1);
    tick();
    check_fetch("beq.bub1", 32'h10, NOP, 32'hC, 1'b0, 1'b1);
    stall = 1'b0;
    tick();
    check_fetch("beq.issue", 32'h14, BEQ, 32'h10, 1'b1, 1'b0);
    stall = 1'b1;
    tick();
    check("hold.is_stall", 32'(is_stall), 32'd1);
    branch_taken = 1'b1; branch_target = 32'h100;
    tick();
    check_fetch("redir_hold", 32'h100, NOP, 32'h10, 1'b0, 1'b0);
    stall = 1'b0; branch_target = 32'hFFFF_FFFE;
    tick();
    check_fetch("redir_misal", 32'hFFFF_FFFC, NOP, 32'h10, 1'b0, 1'b0);
    branch_taken = 1'b0;
    #1 check("wrap.rd", 32'(rd), 32'd2);
    tick();
    check_fetch("wrap", 32'h0, ADDI2, 32'hFFFF_FFFC, 1'b1, 1'b0);
    use_ovr = 1'b1;
    foreach (dec_tab[i]) begin
      ovr = dec_tab[i].w;
      #1 check($sformatf("dec%0d", i), {16'd0, branch, rs1, rs2, rd}, {16'd0, dec_tab[i].exp});
    end
    use_ovr = 1'b0;
    stall = 1'b1; branch_taken = 1'b1; branch_target = 32'h200; rst = 1'b1;
    tick();
    check_fetch("rst_mid", 32'h0, NOP, 32'h0, 1'b0, 1'b0);
    rst = 1'b0; stall = 1'b0; branch_taken = 1'b0;
    tick();
    check_fetch("rst_after", 32'h4, ADDI1, 32'h0, 1'b1, 1'b0);
`ifdef FETCH_PERF_COUNTERS_EN
    rst = 1'b1;
    tick();
    rst = 1'b0; stall = 1'b1;
    tick(); tick(); tick();
    stall = 1'b0; branch_taken = 1'b1; branch_target = 32'h40;
    tick();
    branch_taken = 1'b0;
    tick();
    check("perf.stall", stall_cycles, 32'd3);
    check("perf.bubble", bubble_count, 32'd4);
    check("perf.redirect", redirect_count, 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("perf.clr", stall_cycles | bubble_count | redirect_count, 32'd0);
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
